// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the in-order writeback stage and a
// small FIFO of long-latency results, with a starvation counter that forces FIFO drains.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    p_valid,
  input  logic [4:0]              p_wa,
  input  logic [63:0]             p_wd,
  output logic                    p_stall,
  input  logic                    m_valid,
  input  logic [4:0]              m_wa,
  input  logic [63:0]             m_wd,
  output logic                    m_ready,
  output logic                    rf_wvalid,
  output logic [4:0]              rf_wa,
  output logic [63:0]             rf_wd,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]  wa;
    logic [63:0] wd;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;

  logic   p_req, f_req, force_grant;
  logic   f_gnt, p_gnt;
  logic   enq, deq;
  entry_t head_entry;

  // Request/grant decode and register-file drive. Reset gates every grant so
  // the port is quiet while reset is high, regardless of the pipeline inputs.
  // NOTE: every output is given a default before any branch, so no path through
  // this block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    m_ready     = 1'b0;
    p_stall     = 1'b0;
    rf_wvalid   = 1'b0;
    rf_wa       = '0;
    rf_wd       = '0;
    head_entry  = mem_q[head_q];

    p_req       = p_valid && (p_wa != 5'd0);
    f_req       = (count_q != '0);
    force_grant = (starve_q == LIMIT_C);

    f_gnt       = !reset && f_req && (!p_req || force_grant);
    p_gnt       = !reset && p_req && !f_gnt;

    m_ready     = !reset && (count_q < DEPTH_C);
    enq         = m_valid && m_ready && (m_wa != 5'd0);
    deq         = f_gnt;

    p_stall     = p_req && f_gnt;

    if (f_gnt) begin
      rf_wvalid = 1'b1;
      rf_wa     = head_entry.wa;
      rf_wd     = head_entry.wd;
    end else if (p_gnt) begin
      rf_wvalid = 1'b1;
      rf_wa     = p_wa;
      rf_wd     = p_wd;
    end
  end

  // Next-state for the FIFO pointers, occupancy and starvation counter.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    starve_d = starve_q;

    if (enq) tail_d = tail_q + PW'(1);
    if (deq) head_d = head_q + PW'(1);

    unique case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // The counter only measures how long a waiting head entry has lost.
    if (!f_req || f_gnt) begin
      starve_d = '0;
    end else if (p_gnt) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // NOTE: entry storage is deliberately left out of reset; count_q qualifies
  // every read, so stale contents can never reach the register file.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[tail_q] <= '{wa: m_wa, wd: m_wd};
    end
  end

  assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed literal scenarios plus
// randomized traffic compared every cycle against a queue-based model.
module tb_wb_port_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int MAX_WAIT     = (DEPTH - 1) * (STARVE_LIMIT + 1) + STARVE_LIMIT + 1;
  localparam int RAND_CYCLES  = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_valid;
  logic [4:0]  p_wa;
  logic [63:0] p_wd;
  logic        p_stall;
  logic        m_valid;
  logic [4:0]  m_wa;
  logic [63:0] m_wd;
  logic        m_ready;
  logic        rf_wvalid;
  logic [4:0]  rf_wa;
  logic [63:0] rf_wd;
  logic [1:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .p_valid    (p_valid),
    .p_wa       (p_wa),
    .p_wd       (p_wd),
    .p_stall    (p_stall),
    .m_valid    (m_valid),
    .m_wa       (m_wa),
    .m_wd       (m_wd),
    .m_ready    (m_ready),
    .rf_wvalid  (rf_wvalid),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a queue of buffered results ----------
  typedef struct {
    logic [4:0]  wa;
    logic [63:0] wd;
    int          stamp;
  } item_t;

  item_t q[$];
  int    starve_m = 0;
  int    cyc      = 0;
  bit    preq, freq, fg, pg, rdy;
  logic        exp_wv;
  logic [4:0]  exp_wa;
  logic [63:0] exp_wd;
  int          waited;

  // Inputs change just after the rising edge, so the falling edge sees the
  // values the DUT will act on at the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      check("rst.wvalid", 64'(rf_wvalid), 64'd0);
      check("rst.stall",  64'(p_stall),   64'd0);
      check("rst.ready",  64'(m_ready),   64'd0);
      check("rst.count",  64'(fifo_count), 64'd0);
      q.delete();
      starve_m = 0;
    end else begin
      preq = p_valid && (p_wa != 5'd0);
      freq = (q.size() > 0);
      fg   = freq && (!preq || (starve_m == STARVE_LIMIT));
      pg   = preq && !fg;
      rdy  = (q.size() < DEPTH);

      exp_wv = 1'b0;
      exp_wa = '0;
      exp_wd = '0;
      if (fg) begin
        exp_wv = 1'b1;
        exp_wa = q[0].wa;
        exp_wd = q[0].wd;
      end else if (pg) begin
        exp_wv = 1'b1;
        exp_wa = p_wa;
        exp_wd = p_wd;
      end

      check("mdl.wvalid", 64'(rf_wvalid),  64'(exp_wv));
      check("mdl.wa",     64'(rf_wa),      64'(exp_wa));
      check("mdl.wd",     rf_wd,           exp_wd);
      check("mdl.stall",  64'(p_stall),    64'(preq && fg));
      check("mdl.ready",  64'(m_ready),    64'(rdy));
      check("mdl.count",  64'(fifo_count), 64'(q.size()));

      if (fg) begin
        waited = cyc - q[0].stamp;
        check("mdl.latency_in_bounds", 64'(waited >= 1 && waited <= MAX_WAIT), 64'd1);
      end

      if (!freq || fg) starve_m = 0;
      else if (pg)     starve_m++;
      if (fg) void'(q.pop_front());
      if (m_valid && rdy && (m_wa != 5'd0)) q.push_back('{m_wa, m_wd, cyc});
    end
  end

  // ---------------- directed helpers ----------------------------------------
  task automatic drive(input logic pv, input logic [4:0] pwa, input logic [63:0] pwd,
                       input logic mv, input logic [4:0] mwa, input logic [63:0] mwd);
    @(posedge clk);
    #1;
    p_valid = pv;  p_wa = pwa;  p_wd = pwd;
    m_valid = mv;  m_wa = mwa;  m_wd = mwd;
  endtask

  task automatic look(input string n, input logic wv, input logic [4:0] wa,
                      input logic st, input logic rd, input logic [1:0] cnt);
    #2;
    check({n, ".wvalid"}, 64'(rf_wvalid), 64'(wv));
    if (wv) check({n, ".wa"}, 64'(rf_wa), 64'(wa));
    check({n, ".stall"}, 64'(p_stall),    64'(st));
    check({n, ".ready"}, 64'(m_ready),    64'(rd));
    check({n, ".count"}, 64'(fifo_count), 64'(cnt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    p_valid = 1'b0;  p_wa = '0;  p_wd = '0;
    m_valid = 1'b0;  m_wa = '0;  m_wd = '0;

    // Reset: pipeline request present, yet the port stays quiet.
    drive(1, 5, 64'h5, 1, 6, 64'h6);
    look("in_reset", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    look("post_reset", 0, 0, 0, 1, 0);

    // Single result, idle pipeline.
    drive(0, 0, 0, 1, 3, 64'hAA);
    look("t1_offer", 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    look("t1_write", 1, 3, 0, 1, 1);
    check("t1_write.wd", rf_wd, 64'hAA);
    drive(0, 0, 0, 0, 0, 0);
    look("t1_empty", 0, 0, 0, 1, 0);

    // Fill, backpressure, then forced drain after four lost arbitrations.
    drive(1, 5, 64'h55, 1, 8,  64'h11);  look("t2_a", 1, 5, 0, 1, 0);
    drive(1, 5, 64'h55, 1, 9,  64'h22);  look("t2_b", 1, 5, 0, 1, 1);
    drive(1, 5, 64'h55, 1, 10, 64'h33);  look("t2_c", 1, 5, 0, 0, 2);
    drive(1, 5, 64'h55, 0, 0, 0);        look("t2_d", 1, 5, 0, 0, 2);
    drive(1, 5, 64'h55, 0, 0, 0);        look("t2_e", 1, 5, 0, 0, 2);
    drive(1, 5, 64'h55, 0, 0, 0);        look("t2_f", 1, 8, 1, 0, 2);
    check("t2_f.wd", rf_wd, 64'h11);
    drive(1, 5, 64'h55, 0, 0, 0);        look("t2_g", 1, 5, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0);             look("t2_h", 1, 9, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0);             look("t2_i", 0, 0, 0, 1, 0);

    // Starvation with one buffered entry.
    drive(1, 1, 64'h1, 1, 7, 64'h77);    look("t3_enq", 1, 1, 0, 1, 0);
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      drive(1, 1, 64'h1, 0, 0, 0);       look("t3_win", 1, 1, 0, 1, 1);
    end
    drive(1, 1, 64'h1, 0, 0, 0);         look("t3_force", 1, 7, 1, 1, 1);
    drive(1, 1, 64'h1, 0, 0, 0);         look("t3_after", 1, 1, 0, 1, 0);

    // x0 destinations on both sides.
    drive(0, 0, 0, 1, 4, 64'h44);        look("t4_enq", 0, 0, 0, 1, 0);
    drive(1, 0, 64'hDEAD, 1, 0, 64'h99); look("t4_x0", 1, 4, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0);             look("t4_after", 0, 0, 0, 1, 0);

    // Full FIFO with a same-cycle dequeue is still not ready.
    drive(1, 2, 64'h2, 1, 11, 64'hB1);   look("t5_a", 1, 2, 0, 1, 0);
    drive(1, 2, 64'h2, 1, 12, 64'hB2);   look("t5_b", 1, 2, 0, 1, 1);
    drive(0, 0, 0, 1, 13, 64'hB3);       look("t5_full", 1, 11, 0, 0, 2);
    drive(0, 0, 0, 1, 13, 64'hB3);       look("t5_accept", 1, 12, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0);             look("t5_steady", 1, 13, 0, 1, 1);
    check("t5_steady.wd", rf_wd, 64'hB3);
    drive(0, 0, 0, 0, 0, 0);             look("t5_empty", 0, 0, 0, 1, 0);

    // Reset asserted mid-cycle with two buffered entries.
    drive(1, 2, 64'h2, 1, 14, 64'hC1);   look("t6_a", 1, 2, 0, 1, 0);
    drive(1, 2, 64'h2, 1, 15, 64'hC2);   look("t6_b", 1, 2, 0, 1, 1);
    drive(1, 2, 64'h2, 0, 0, 0);         look("t6_full", 1, 2, 0, 0, 2);
    reset = 1'b1;
    #1;
    check("t6_rst.wvalid", 64'(rf_wvalid),  64'd0);
    check("t6_rst.ready",  64'(m_ready),    64'd0);
    check("t6_rst.count",  64'(fifo_count), 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    look("t6_release", 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0);             look("t6_quiet", 0, 0, 0, 1, 0);

    // Randomized traffic; the negedge model checks every cycle.
    for (int i = 0; i < RAND_CYCLES; i++) begin
      @(posedge clk);
      #1;
      reset   = ($urandom_range(0, 399) == 0);
      p_valid = ($urandom_range(0, 9) < 7);
      p_wa    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      p_wd    = {$urandom, $urandom};
      m_valid = ($urandom_range(0, 1) == 1);
      m_wa    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      m_wd    = {$urandom, $urandom};
    end
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    repeat (MAX_WAIT + 2) @(posedge clk);
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single integer register-file write port between the in-order pipeline writeback stage and the long-latency execution units (multiply/divide), which return results out of step with the pipeline. Accepted long-latency results are buffered in a small FIFO. The pipeline normally wins the port; a starvation counter forces a FIFO grant, and the pipeline is stalled for that cycle. The block sits between the writeback stage and the register file's write port.

## Interface
Parameters:
- DEPTH, 2, long-latency result FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 4, consecutive lost arbitrations before the FIFO is forced; at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- p_valid  in  1  pipeline writeback requests a register write.
- p_wa  in  5  pipeline destination register.
- p_wd  in  64  pipeline write data.
- p_stall  out  1  pipeline must hold its writeback inputs this cycle.
- m_valid  in  1  long-latency unit offers a result.
- m_wa  in  5  long-latency destination register.
- m_wd  in  64  long-latency result data.
- m_ready  out  1  the FIFO accepts the offered result this cycle.
- rf_wvalid  out  1  register-file write enable.
- rf_wa  out  5  register-file write address.
- rf_wd  out  64  register-file write data.
- fifo_count  out  clog2(DEPTH)+1  number of buffered entries.

## Operation
- The FIFO holds {wa, wd} entries. Its state is a count, a head pointer and a tail pointer; pointers wrap modulo DEPTH.
- m_ready = (count < DEPTH). It is independent of a same-cycle dequeue, so a full FIFO is never ready.
- A result is accepted on m_valid && m_ready:
  - m_wa == 0: the result is consumed and discarded, not enqueued.
  - otherwise: the result is written at the tail.
- Request terms:
  - p_req = p_valid && (p_wa != 0).
  - f_req = (count > 0).
  - A p_valid with p_wa == 0 is a no-op. It never uses the port and never stalls.
- Starvation counter starve, width clog2(STARVE_LIMIT+1):
  - force = (starve == STARVE_LIMIT).
  - Increments when f_req && p_req and the pipeline wins.
  - Clears to 0 on any FIFO grant, and whenever f_req == 0.
- Grant rules, evaluated each cycle:
  - FIFO granted when f_req && (!p_req || force). rf_* takes the head entry; the head is dequeued at the edge.
  - Otherwise pipeline granted when p_req. rf_* = {1, p_wa, p_wd}.
  - Otherwise rf_wvalid = 0, rf_wa = 0, rf_wd = 0.
- p_stall = p_req && FIFO granted. It is asserted only on a forced grant. The pipeline re-presents the same request next cycle, and that request then wins, since starve == 0.
- A forced grant covers exactly one entry. Afterwards normal pipeline priority resumes.
- Simultaneous enqueue and dequeue (count < DEPTH): count is unchanged and both pointers advance.
- There is no bypass. An entry accepted at edge N is granted no earlier than the cycle after edge N.
- WAW ordering between the pipeline and buffered results is guaranteed upstream by the hazard/scoreboard logic. This block does not check it.

## Timing
- Register-file write outputs are combinational from p_* and the FIFO head in the same cycle. Writeback latency for pipeline requests is zero.
- Long-latency path: at least 1 cycle from handshake to write. At most (DEPTH − 1)·(STARVE_LIMIT + 1) + STARVE_LIMIT + 1 cycles under continuous pipeline traffic.
- While reset is high, the following are forced low: rf_wvalid, p_stall, m_ready.
- Reset values: count 0, head 0, tail 0, starve 0, fifo_count 0.
- Asserting reset mid-operation discards all buffered entries immediately. No stale write appears after deassertion.
- First cycle after deassertion: m_ready = 1, rf_* follows p_* only.

## Test plan
- Single result, idle pipeline: m_valid for 1 cycle with m_wa=3, m_wd=0xAA; p_valid=0 -> next cycle rf_wvalid=1, rf_wa=3, rf_wd=0xAA; fifo_count 1→0; m_ready stays 1.
- Fill and backpressure: DEPTH=2; p_valid=1, p_wa=5 held; m_valid on 3 consecutive cycles -> first two accepted; third cycle m_ready=0, fifo_count=2; rf_wa=5 throughout until starvation.
- Starvation: STARVE_LIMIT=4; one buffered entry (wa=7); continuous p_valid with p_wa=1 -> pipeline granted 4 cycles; 5th cycle rf_wa=7, p_stall=1; 6th cycle rf_wa=1, p_stall=0, fifo_count=0.
- x0 handling: p_valid=1, p_wa=0 with one buffered entry -> FIFO granted that cycle, p_stall=0. m_valid with m_wa=0 -> m_ready=1 and fifo_count unchanged.
- Full with dequeue: count=2, p_valid=0, m_valid=1 -> m_ready=0 that cycle with head written; next cycle m_ready=1, the result is accepted, and count stays 1 while the next entry drains.
- Reset mid-operation: count=2, reset pulsed between edges -> rf_wvalid and m_ready go low immediately. After release fifo_count=0, m_ready=1, and no rf_wvalid without p_valid.
